// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: CDB record, machine word, source index.
package lc3b_types;

    localparam int data_width = 16;
    localparam int tag_width  = 3;
    localparam int MAX_SRC    = 8;

    typedef logic [data_width-1:0]      lc3b_word;
    typedef logic [tag_width-1:0]       lc3b_tag;
    typedef logic [$clog2(MAX_SRC)-1:0] cdb_src_t;

    typedef struct packed {
        logic     valid;
        lc3b_tag  tag;
        lc3b_word data;
    } cdb_t;

    localparam cdb_t CDB_IDLE = '0;

    // (base + off) mod n for base < n and off < n, without a divider
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: first requester at or after ptr, with wrap.
module rr_priority_pick
    import lc3b_types::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] winner,
    output logic          found
);

    int idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = wrap_idx(int'(ptr), k, N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant, registered single broadcast record.
module cdb_arbiter
    import lc3b_types::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               flush,
    input  cdb_t               CDB_req [NUM_SRC],
    output logic [NUM_SRC-1:0] grant,
    output cdb_t               CDB_out,
    output logic               busy
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] req_v;
    logic [NUM_SRC-1:0] pick_grant;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      winner;
    logic [PW-1:0]      ptr_next;
    logic               found;

    always_comb begin
        req_v = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            req_v[i] = CDB_req[i].valid;
        end
    end

    rr_priority_pick #(
        .N  (NUM_SRC),
        .PW (PW)
    ) u_pick (
        .req    (req_v),
        .ptr    (rr_ptr),
        .grant  (pick_grant),
        .winner (winner),
        .found  (found)
    );

    // No station may retire while the pipeline is being flushed
    assign grant = flush ? '0 : pick_grant;
    assign busy  = |req_v;

    assign ptr_next = (winner == PW'(NUM_SRC - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk) begin
        if (flush) begin
            CDB_out <= CDB_IDLE;
            rr_ptr  <= '0;
        end else if (found) begin
            CDB_out <= CDB_req[winner];
            rr_ptr  <= ptr_next;
        end else begin
            CDB_out <= CDB_IDLE;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized checks for the CDB round-robin arbiter.
module tb_cdb_arbiter;
    import lc3b_types::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         flush;
    cdb_t         req [N];
    logic [N-1:0] grant;
    cdb_t         cdb_out;
    logic         busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_SRC(N)) dut (
        .clk     (clk),
        .flush   (flush),
        .CDB_req (req),
        .grant   (grant),
        .CDB_out (cdb_out),
        .busy    (busy)
    );

    function automatic cdb_t mk(input logic v, input lc3b_tag t, input lc3b_word d);
        cdb_t r;
        r.valid = v;
        r.tag   = t;
        r.data  = d;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        for (int i = 0; i < N; i++) req[i] = '0;
    endtask

    task automatic do_flush;
        flush = 1'b1;
        idle_all();
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset;
        flush = 1'b1;
        for (int i = 0; i < N; i++) req[i] = mk(1'b1, lc3b_tag'(i), 16'h5000 + 16'(i));
        #2;
        total++;
        if (grant !== 4'b0000) $display("FAIL reset_grant0 got=%b exp=0000", grant);
        else passed++;
        tick();
        total++;
        if (cdb_out !== CDB_IDLE) $display("FAIL reset_out0 got=%h exp=%h", cdb_out, CDB_IDLE);
        else passed++;
        total++;
        if (grant !== 4'b0000) $display("FAIL reset_grant1 got=%b exp=0000", grant);
        else passed++;
        tick();
        total++;
        if (cdb_out !== CDB_IDLE) $display("FAIL reset_out1 got=%h exp=%h", cdb_out, CDB_IDLE);
        else passed++;
        flush = 1'b0;
        #1;
        total++;
        if (grant !== 4'b0001) $display("FAIL reset_ptr0 got=%b exp=0001", grant);
        else passed++;
        total++;
        if (busy !== 1'b1) $display("FAIL reset_busy got=%b exp=1", busy);
        else passed++;
        tick();
        total++;
        if (cdb_out !== mk(1'b1, 3'd0, 16'h5000))
            $display("FAIL reset_first_bcast got=%h exp=%h", cdb_out, mk(1'b1, 3'd0, 16'h5000));
        else passed++;
        do_flush();
    endtask

    task automatic test_single;
        req[2] = mk(1'b1, 3'd5, 16'h1234);
        #1;
        total++;
        if (grant !== 4'b0100) $display("FAIL single_grant got=%b exp=0100", grant);
        else passed++;
        tick();
        total++;
        if (cdb_out !== mk(1'b1, 3'd5, 16'h1234))
            $display("FAIL single_out got=%h exp=%h", cdb_out, mk(1'b1, 3'd5, 16'h1234));
        else passed++;
        req[2] = '0;
        #1;
        total++;
        if (grant !== 4'b0000) $display("FAIL single_nogrant got=%b exp=0000", grant);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL single_busy got=%b exp=0", busy);
        else passed++;
        tick();
        total++;
        if (cdb_out.valid !== 1'b0) $display("FAIL single_drop got=%b exp=0", cdb_out.valid);
        else passed++;
    endtask

    task automatic test_rotate;
        cdb_t e;
        do_flush();
        for (int i = 0; i < N; i++) req[i] = mk(1'b1, lc3b_tag'(i), 16'hA000 + 16'(i));
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (grant !== 4'(1 << (k % N)))
                $display("FAIL rotate_grant%0d got=%b exp=%b", k, grant, 4'(1 << (k % N)));
            else passed++;
            tick();
            e = mk(1'b1, lc3b_tag'(k % N), 16'hA000 + 16'(k % N));
            total++;
            if (cdb_out !== e) $display("FAIL rotate_out%0d got=%h exp=%h", k, cdb_out, e);
            else passed++;
        end
        idle_all();
    endtask

    task automatic test_back_to_back;
        do_flush();
        for (int k = 0; k < 4; k++) begin
            req[1] = mk(1'b1, lc3b_tag'(k), 16'h0100 + 16'(k));
            #1;
            total++;
            if (grant !== 4'b0010) $display("FAIL b2b_grant%0d got=%b exp=0010", k, grant);
            else passed++;
            tick();
            total++;
            if (cdb_out !== mk(1'b1, lc3b_tag'(k), 16'h0100 + 16'(k)))
                $display("FAIL b2b_out%0d got=%h exp=%h", k, cdb_out,
                         mk(1'b1, lc3b_tag'(k), 16'h0100 + 16'(k)));
            else passed++;
        end
        idle_all();
    endtask

    task automatic test_wrap;
        do_flush();
        req[3] = mk(1'b1, 3'd7, 16'hBEEF);
        #1;
        total++;
        if (grant !== 4'b1000) $display("FAIL wrap_g3 got=%b exp=1000", grant);
        else passed++;
        tick();
        total++;
        if (cdb_out !== mk(1'b1, 3'd7, 16'hBEEF))
            $display("FAIL wrap_out3 got=%h exp=%h", cdb_out, mk(1'b1, 3'd7, 16'hBEEF));
        else passed++;
        req[3] = mk(1'b1, 3'd6, 16'hCAFE);
        req[0] = mk(1'b1, 3'd1, 16'h0001);
        #1;
        total++;
        if (grant !== 4'b0001) $display("FAIL wrap_g0 got=%b exp=0001", grant);
        else passed++;
        tick();
        total++;
        if (cdb_out !== mk(1'b1, 3'd1, 16'h0001))
            $display("FAIL wrap_out0 got=%h exp=%h", cdb_out, mk(1'b1, 3'd1, 16'h0001));
        else passed++;
        req[0] = '0;
        #1;
        total++;
        if (grant !== 4'b1000) $display("FAIL wrap_g3b got=%b exp=1000", grant);
        else passed++;
        tick();
        total++;
        if (cdb_out !== mk(1'b1, 3'd6, 16'hCAFE))
            $display("FAIL wrap_out3b got=%h exp=%h", cdb_out, mk(1'b1, 3'd6, 16'hCAFE));
        else passed++;
        idle_all();
    endtask

    task automatic test_flush_mid;
        logic [N-1:0] eg;
        cdb_t         eo;
        for (int v = 0; v < 2; v++) begin
            do_flush();
            req[1] = mk(1'b1, 3'd2, 16'h1111);
            req[2] = mk(1'b1, 3'd3, 16'h2222);
            #1;
            total++;
            if (grant !== 4'b0010) $display("FAIL fmid%0d_g1 got=%b exp=0010", v, grant);
            else passed++;
            tick();
            req[1] = (v == 0) ? mk(1'b1, 3'd4, 16'h3333) : '0;
            flush  = 1'b1;
            #1;
            total++;
            if (grant !== 4'b0000) $display("FAIL fmid%0d_nogrant got=%b exp=0000", v, grant);
            else passed++;
            total++;
            if (cdb_out !== mk(1'b1, 3'd2, 16'h1111))
                $display("FAIL fmid%0d_latched got=%h exp=%h", v, cdb_out,
                         mk(1'b1, 3'd2, 16'h1111));
            else passed++;
            tick();
            total++;
            if (cdb_out.valid !== 1'b0) $display("FAIL fmid%0d_drop got=%b exp=0", v, cdb_out.valid);
            else passed++;
            flush = 1'b0;
            eg = (v == 0) ? 4'b0010 : 4'b0100;
            eo = (v == 0) ? mk(1'b1, 3'd4, 16'h3333) : mk(1'b1, 3'd3, 16'h2222);
            #1;
            total++;
            if (grant !== eg) $display("FAIL fmid%0d_after got=%b exp=%b", v, grant, eg);
            else passed++;
            tick();
            total++;
            if (cdb_out !== eo) $display("FAIL fmid%0d_out got=%h exp=%h", v, cdb_out, eo);
            else passed++;
            idle_all();
        end
    endtask

    task automatic test_random;
        cdb_t         cur [N];
        cdb_t         prev [N];
        bit           pend [N];
        bit           hold [N];
        int           wait_c [N];
        int           ptr_m;
        int           w;
        int           idx;
        int           gen;
        int           bc;
        int           npend;
        bit           exp_v;
        cdb_t         exp_rec;
        logic [N-1:0] eg;
        do_flush();
        ptr_m = 0;
        gen   = 0;
        bc    = 0;
        exp_v = 1'b0;
        exp_rec = '0;
        for (int i = 0; i < N; i++) begin
            cur[i]    = '0;
            prev[i]   = '0;
            pend[i]   = 1'b0;
            hold[i]   = 1'b0;
            wait_c[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            if (c > 0) begin
                total++;
                if (exp_v ? (cdb_out !== exp_rec) : (cdb_out.valid !== 1'b0))
                    $display("FAIL rnd_out c=%0d got=%h exp=%h v=%b", c, cdb_out, exp_rec, exp_v);
                else passed++;
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    cur[i] = mk(1'b1, lc3b_tag'($urandom), lc3b_word'($urandom));
                    pend[i]   = 1'b1;
                    wait_c[i] = 0;
                    gen++;
                end
                req[i] = pend[i] ? cur[i] : '0;
            end
            for (int i = 0; i < N; i++) begin
                if (hold[i]) begin
                    total++;
                    if (req[i] !== prev[i])
                        $display("FAIL rnd_hold src=%0d got=%h exp=%h", i, req[i], prev[i]);
                    else passed++;
                end
            end
            #1;
            eg = '0;
            w  = 0;
            for (int k = 0; k < N; k++) begin
                idx = (ptr_m + k) % N;
                if (eg == '0 && pend[idx]) begin
                    eg[idx] = 1'b1;
                    w = idx;
                end
            end
            total++;
            if (grant !== eg) $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, grant, eg);
            else passed++;
            if (eg != '0) begin
                exp_v   = 1'b1;
                exp_rec = cur[w];
                ptr_m   = (w + 1) % N;
                bc++;
                total++;
                if (wait_c[w] >= N) $display("FAIL rnd_wait src=%0d got=%0d exp=<%0d", w, wait_c[w], N);
                else passed++;
                pend[w] = 1'b0;
            end else begin
                exp_v = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                prev[i] = req[i];
                hold[i] = pend[i];
                if (pend[i]) wait_c[i]++;
            end
            tick();
        end
        total++;
        if (exp_v ? (cdb_out !== exp_rec) : (cdb_out.valid !== 1'b0))
            $display("FAIL rnd_out_last got=%h exp=%h v=%b", cdb_out, exp_rec, exp_v);
        else passed++;
        npend = 0;
        for (int i = 0; i < N; i++) if (pend[i]) npend++;
        total++;
        if (bc !== gen - npend) $display("FAIL rnd_count got=%0d exp=%0d", bc, gen - npend);
        else passed++;
        idle_all();
    endtask

    initial begin
        flush = 1'b1;
        idle_all();
        test_reset();
        test_single();
        test_rotate();
        test_back_to_back();
        test_wrap();
        test_flush_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Consumer end of the common data bus (CDB) result protocol.
- Each reservation station (ALU, load/store, etc.) presents a CDB record {valid, tag, data} while its result is ready.
- The arbiter grants one requester per cycle by round-robin. It registers the winner's record onto the single broadcast bus, which feeds all stations, the register file and the reorder buffer.
- The grant tells the winning station to release its entry (drop busy).

Parameters:
- NUM_SRC, 4, number of requesting stations (2..8).
- data_width, 16, CDB data width.
- tag_width, 3, CDB tag (ROB index) width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- flush  input  1  synchronous, active-high reset/flush; sampled on posedge clk.
- CDB_req  input  CDB[NUM_SRC]  per-station result record (lc3b_types CDB struct); .valid = request.
- grant  output  NUM_SRC  one-hot combinational grant; station i retires its result in the cycle grant[i]=1.
- CDB_out  output  CDB  registered broadcast record {valid, tag, data}.
- busy  output  1  combinational; 1 when any CDB_req[i].valid=1 this cycle.

Behaviour:
- Reset/flush:
  - On posedge clk with flush=1, CDB_out.valid<=0, CDB_out.tag<=0, CDB_out.data<=0, and rr_ptr<=0.
  - grant is forced to all-zero in any cycle where flush=1, so no station retires during a flush.
- State:
  - rr_ptr is a log2(NUM_SRC)-bit register naming the highest-priority source.
  - The output register holds CDB_out.
- Arbitration (combinational):
  - Scan sources rr_ptr, rr_ptr+1, ..., rr_ptr+NUM_SRC-1, modulo NUM_SRC (wrap from NUM_SRC-1 to 0).
  - The first source with CDB_req[i].valid=1 wins and grant[i]=1.
  - No requests -> grant=0.
- Latency:
  - A record granted in cycle N appears on CDB_out in cycle N+1 with valid=1 for exactly one cycle, unless another grant occurs in N+1.
  - Cycle N with no grant -> CDB_out.valid=0 in cycle N+1.
- Pointer update: on a grant to source w with flush=0, rr_ptr<=(w+1) mod NUM_SRC. With no grant, rr_ptr holds.
- Fairness: a source holding valid continuously is granted within NUM_SRC cycles.
- Handshake rules:
  - A station holds CDB_req stable and valid until it sees grant=1. It clears valid the following cycle.
  - The arbiter does not re-sample the record after the grant edge.
  - Changing tag/data while valid=1 and ungranted is illegal; a bench assertion flags it.
- Boundary conditions:
  - All sources requesting: grants rotate 0,1,2,3,0,... with one broadcast every cycle and no bubbles.
  - A single source requesting back-to-back records is granted every cycle.
  - Simultaneous flush and requests: no grant, CDB_out.valid=0 next cycle, rr_ptr=0.
  - flush asserted mid-stream: the record already latched is dropped; CDB_out.valid=0 after the edge.
  - Duplicate tags from two sources are not checked; they are broadcast in grant order.
- CDB_out is never X after the first flush.

Decomposition:
- The CDB struct, lc3b_word, and a cdb_src_t index typedef (sized for 8 sources) belong in lc3b_types.
- One sub-module is natural: rr_priority_pick (parameter N; inputs req[N], ptr; outputs one-hot grant and winner index). It is purely combinational.
- cdb_arbiter holds rr_ptr, the output register, and the flush gating.

Test Plan:
- flush=1 for 2 cycles with all sources requesting -> grant=0000, CDB_out.valid=0, rr_ptr=0.
- Only source 2 valid, tag=5, data=0x1234 at cycle N -> grant=0100 at N; CDB_out={1,5,0x1234} at N+1; CDB_out.valid=0 at N+2 after source drops.
- All 4 sources valid continuously with tags 0..3 -> grants 0001,0010,0100,1000,0001; CDB_out tags 0,1,2,3,0 on consecutive cycles.
- After a grant to source 3, sources 0 and 3 both request -> source 0 wins (wrap-around); source 3 is granted next cycle.
- Sources 1 and 2 requesting, flush asserted the cycle after source 1's grant -> CDB_out.valid=0 after the flush edge, no grant that cycle, rr_ptr=0. Next cycle source 1 wins if it still requests, otherwise source 2.
- Randomized requests held until granted over 10k cycles -> every record is broadcast exactly once, max wait < NUM_SRC cycles, no tag/data change while pending.
